// File: rtl/pc_pkg.sv
// Shared types and default widths for the 3BC program-counter / fetch stage.
// The branch lookup table imports the same widths so both sides agree on Offset.
package pc_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int OFS_W_DEF = 11;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: hold on halt, relative branch, else sequential.
// Also used by reference models, so it carries no state and no stall handling.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFS_W = OFS_W_DEF
) (
  input  logic [PC_W-1:0]  i_pc,
  input  logic [OFS_W-1:0] i_offset,
  input  logic             i_branch_taken,
  input  logic             i_halt,
  output logic [PC_W-1:0]  o_next_pc
);

  logic [PC_W:0] w_ofs_ext;
  logic [PC_W:0] w_sum;

  // Sign-extend to PC_W+1 and keep the low PC_W bits: wrap in either direction is silent.
  assign w_ofs_ext = (PC_W+1)'($signed(i_offset));
  assign w_sum     = {1'b0, i_pc} + w_ofs_ext;

  always_comb begin
    o_next_pc = i_pc + PC_W'(1);
    if (i_halt) begin
      o_next_pc = i_pc;
    end else if (i_branch_taken) begin
      o_next_pc = w_sum[PC_W-1:0];
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and run sequencer (IDLE -> RUN -> DONE) with a saturating
// retired-instruction counter. All outputs come from registers or state decode.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFS_W = OFS_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [OFS_W-1:0] Offset,
  input  logic             Halt,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount,
  output pc_state_t        o_dbg_state
);

  pc_state_t        r_state;
  pc_state_t        w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;
  logic [PC_W-1:0]  w_next_pc;

  pc_next_calc #(
    .PC_W  (PC_W),
    .OFS_W (OFS_W)
  ) u_next (
    .i_pc           (r_pc),
    .i_offset       (Offset),
    .i_branch_taken (BranchTaken),
    .i_halt         (Halt),
    .o_next_pc      (w_next_pc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // DONE waits for Start to drop so a held Start cannot trigger an immediate re-run.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (Start) w_state_nxt = RUN;
      RUN:     if (!Stall && Halt) w_state_nxt = DONE;
      DONE:    if (!Start) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pc  <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_pc  <= StartAddr;
            r_cnt <= '0;
          end
        end
        RUN: begin
          if (!Stall) begin
            r_pc <= w_next_pc;
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Running     = (r_state == RUN);
    Done        = (r_state == DONE);
    ProgCtr     = r_pc;
    InstCount   = r_cnt;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a vector table for the single-cycle behaviour
// plus hand-written sequences for async reset and counter saturation.
module tb_pc_fetch_ctrl;
  import pc_pkg::*;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        Stall;
  logic        BranchTaken;
  logic [10:0] Offset;
  logic        Halt;
  logic [9:0]  ProgCtr;
  logic        Running;
  logic        Done;
  logic [15:0] InstCount;
  pc_state_t   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        start;
    logic [9:0]  addr;
    logic        stall;
    logic        br;
    logic [10:0] ofs;
    logic        halt;
    logic [9:0]  e_pc;
    logic        e_run;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .Offset      (Offset),
    .Halt        (Halt),
    .ProgCtr     (ProgCtr),
    .Running     (Running),
    .Done        (Done),
    .InstCount   (InstCount),
    .o_dbg_state (dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void add(input logic start, input int addr, input logic stall,
                              input logic br, input int ofs, input logic halt,
                              input int e_pc, input logic e_run, input logic e_done,
                              input int e_cnt);
    vec_t v;
    v.start = start;  v.addr = 10'(addr); v.stall = stall; v.br = br;
    v.ofs   = 11'(ofs); v.halt = halt;   v.e_pc  = 10'(e_pc);
    v.e_run = e_run;  v.e_done = e_done; v.e_cnt = 16'(e_cnt);
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic start, input logic [9:0] addr, input logic stall,
                       input logic br, input logic [10:0] ofs, input logic halt);
    Start = start; StartAddr = addr; Stall = stall;
    BranchTaken = br; Offset = ofs; Halt = halt;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] e_pc, input logic e_run,
                       input logic e_done, input logic [15:0] e_cnt);
    n_checks++;
    if (ProgCtr !== e_pc || Running !== e_run || Done !== e_done || InstCount !== e_cnt) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d run=%0b done=%0b cnt=%0d, want pc=%0d run=%0b done=%0b cnt=%0d",
               name, ProgCtr, Running, Done, InstCount, e_pc, e_run, e_done, e_cnt);
    end
  endtask

  initial begin
    // start addr stall br ofs halt | pc run done cnt
    add(1, 0, 0, 0, 0, 0,   0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, i);
    add(0, 0, 0, 1,  392, 0,  400, 1, 0,  9);
    add(0, 0, 0, 1, -370, 0,   30, 1, 0, 10);
    add(0, 0, 0, 1,  -10, 0,   20, 1, 0, 11);
    add(0, 0, 0, 1, -370, 0,  674, 1, 0, 12);
    add(0, 0, 0, 1,  349, 0, 1023, 1, 0, 13);
    add(0, 0, 0, 0,    0, 0,    0, 1, 0, 14);
    add(0, 0, 0, 1,    5, 0,    5, 1, 0, 15);
    add(0, 0, 1, 1,   40, 1,    5, 1, 0, 15);
    add(0, 0, 1, 0,    0, 1,    5, 1, 0, 15);
    add(0, 0, 1, 1,   -3, 0,    5, 1, 0, 15);
    add(0, 0, 0, 1,   52, 0,   57, 1, 0, 16);
    add(0, 0, 0, 1,  100, 1,   57, 0, 1, 17);
    add(1, 0, 0, 0,    0, 0,   57, 0, 1, 17);
    add(1, 3, 0, 0,    0, 0,   57, 0, 1, 17);
    add(0, 0, 0, 0,    0, 0,   57, 0, 0, 17);
    add(0, 0, 0, 0,    0, 0,   57, 0, 0, 17);
    add(1, 190, 0, 0,  0, 0,  190, 1, 0,  0);
    add(1, 0, 0, 0,    0, 0,  191, 1, 0,  1);
    add(0, 0, 0, 1,    9, 0,  200, 1, 0,  2);

    drive(0, 10'd0, 0, 0, 11'd0, 0);
    Reset_n = 1'b0;
    #3;
    check("reset_state", 10'd0, 1'b0, 1'b0, 16'd0);
    #9 Reset_n = 1'b1;
    step();
    check("idle_after_reset", 10'd0, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].addr, vecs[i].stall, vecs[i].br, vecs[i].ofs, vecs[i].halt);
      step();
      check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_run, vecs[i].e_done, vecs[i].e_cnt);
    end

    // Async reset between edges while running at PC=200.
    drive(0, 10'd0, 0, 0, 11'd0, 0);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_reset_midrun", 10'd0, 1'b0, 1'b0, 16'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("no_run_without_start", 10'd0, 1'b0, 1'b0, 16'd0);

    // Self-loop long enough to saturate the counter.
    drive(1, 10'd0, 0, 0, 11'd0, 0);
    step();
    check("restart", 10'd0, 1'b1, 1'b0, 16'd0);
    drive(0, 10'd0, 0, 1, 11'd0, 0);
    for (int i = 1; i <= 70000; i++) begin
      step();
      if (i == 65534) check("cnt_below_sat", 10'd0, 1'b1, 1'b0, 16'd65534);
      if (i == 65535) check("cnt_at_sat", 10'd0, 1'b1, 1'b0, 16'd65535);
    end
    check("cnt_saturated", 10'd0, 1'b1, 1'b0, 16'd65535);
    drive(0, 10'd0, 0, 0, 11'd0, 1);
    step();
    check("halt_at_sat", 10'd0, 1'b0, 1'b1, 16'd65535);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
